intersection_scheduler: RTL and testbench



---
 rtl/intersection_pkg.sv | 20 ++
 rtl/intersection_scheduler_phase_timer.sv | 33 +++
 rtl/intersection_scheduler.sv | 119 +++++++++++
 tb/tb_intersection_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection scheduler: lamp colours, FSM state
// codes (also exported on the debug phase port) and the phase width.
package intersection_pkg;

  localparam int PHASE_W = 3;

  localparam logic [1:0] LIGHT_RED    = 2'd0;
  localparam logic [1:0] LIGHT_GREEN  = 2'd1;
  localparam logic [1:0] LIGHT_YELLOW = 2'd2;

  typedef enum logic [PHASE_W-1:0] {
    ST_CLEAR    = 3'd0,
    ST_GREEN_A  = 3'd1,
    ST_YELLOW_A = 3'd2,
    ST_GREEN_B  = 3'd3,
    ST_YELLOW_B = 3'd4,
    ST_PED_WALK = 3'd5
  } state_e;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Time-in-phase counter: synchronous clear, saturating increment so that a
// long rest never wraps back below the minimum-green threshold.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/intersection_scheduler.sv
// Actuated phase scheduler for two approaches plus a pedestrian crossing.
// Moore FSM: outputs decode only from the state register.
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1,
  parameter int PED_T     = 3,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_a,
  input  logic               req_b,
  input  logic               ped_req,
  output logic [1:0]         sig_a,
  output logic [1:0]         sig_b,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_T - 1);

  state_e           state_q, state_d;
  logic             ped_q, ped_d;
  logic             last_b_q, last_b_d;   // 1: approach B was served last
  logic [CNT_W-1:0] cnt;
  logic             conflict_a, conflict_b;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_d != state_q),
    .cnt_o (cnt)
  );

  assign conflict_a = req_b | ped_q;
  assign conflict_b = req_a | ped_q;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      ST_CLEAR: begin
        // Serve the approach that waited longest before the one just served.
        if (cnt == ALLRED_LAST) begin
          if (ped_q)                        state_d = ST_PED_WALK;
          else if (last_b_q ? req_a : req_b) state_d = last_b_q ? ST_GREEN_A : ST_GREEN_B;
          else if (last_b_q ? req_b : req_a) state_d = last_b_q ? ST_GREEN_B : ST_GREEN_A;
          else                              state_d = ST_GREEN_A;
        end
      end
      ST_GREEN_A: begin
        if (cnt >= MIN_LAST && conflict_a && (!req_a || cnt >= MAX_LAST))
          state_d = ST_YELLOW_A;
      end
      ST_GREEN_B: begin
        if (cnt >= MIN_LAST && (!req_b || (conflict_b && cnt >= MAX_LAST)))
          state_d = ST_YELLOW_B;
      end
      ST_YELLOW_A: begin
        if (cnt == YELLOW_LAST) begin
          state_d  = ST_CLEAR;
          last_b_d = 1'b0;
        end
      end
      ST_YELLOW_B: begin
        if (cnt == YELLOW_LAST) begin
          state_d  = ST_CLEAR;
          last_b_d = 1'b1;
        end
      end
      ST_PED_WALK: begin
        if (cnt == PED_LAST) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase

    // Entering the walk consumes the request even if the button is held.
    ped_d = ped_q;
    if (ped_req && state_q != ST_PED_WALK) ped_d = 1'b1;
    if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) ped_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      ped_q    <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ped_q    <= ped_d;
      last_b_q <= last_b_d;
    end
  end

  always_comb begin
    sig_a = LIGHT_RED;
    sig_b = LIGHT_RED;
    walk  = 1'b0;
    unique case (state_q)
      ST_GREEN_A:  sig_a = LIGHT_GREEN;
      ST_YELLOW_A: sig_a = LIGHT_YELLOW;
      ST_GREEN_B:  sig_b = LIGHT_GREEN;
      ST_YELLOW_B: sig_b = LIGHT_YELLOW;
      ST_PED_WALK: walk  = 1'b1;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed scenarios plus randomized traffic, checked against a behavioural
// model that tracks phase, elapsed time, pending walk and last-served approach.
module tb_intersection_scheduler;

  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 12;
  localparam int YELLOW_T  = 2;
  localparam int ALL_RED_T = 1;
  localparam int PED_T     = 3;
  localparam int CNT_W     = 8;

  localparam int P_CLEAR = 0, P_GA = 1, P_YA = 2, P_GB = 3, P_YB = 4, P_WALK = 5;
  localparam logic [1:0] RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2;

  logic clk = 1'b0;
  logic reset, req_a, req_b, ped_req;
  logic [1:0] sig_a, sig_b;
  logic walk;
  logic [2:0] phase;

  int passed = 0;
  int total  = 0;

  // reference model state
  int m_ph = P_CLEAR;
  int m_t = 0;
  bit m_ped = 0;
  bit m_last_b = 1;

  intersection_scheduler #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_T(YELLOW_T),
    .ALL_RED_T(ALL_RED_T), .PED_T(PED_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
    .sig_a(sig_a), .sig_b(sig_b), .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic model_update(input bit r, input bit a, input bit b, input bit p);
    int nph;
    nph = m_ph;
    if (r) begin
      m_ph = P_CLEAR; m_t = 0; m_ped = 0; m_last_b = 1;
      return;
    end
    case (m_ph)
      P_CLEAR: if (m_t == ALL_RED_T - 1) begin
        if (m_ped)                   nph = P_WALK;
        else if (m_last_b ? a : b)   nph = m_last_b ? P_GA : P_GB;
        else if (m_last_b ? b : a)   nph = m_last_b ? P_GB : P_GA;
        else                         nph = P_GA;
      end
      P_GA: if (m_t >= MIN_GREEN - 1 && (b || m_ped) && (!a || m_t >= MAX_GREEN - 1)) nph = P_YA;
      P_GB: if (m_t >= MIN_GREEN - 1 && (!b || ((a || m_ped) && m_t >= MAX_GREEN - 1))) nph = P_YB;
      P_YA: if (m_t == YELLOW_T - 1) begin nph = P_CLEAR; m_last_b = 0; end
      P_YB: if (m_t == YELLOW_T - 1) begin nph = P_CLEAR; m_last_b = 1; end
      P_WALK: if (m_t == PED_T - 1) nph = P_CLEAR;
      default: ;
    endcase
    if (nph == P_WALK && m_ph != P_WALK) m_ped = 0;
    else if (p && m_ph != P_WALK)        m_ped = 1;
    m_t  = (nph != m_ph) ? 0 : m_t + 1;
    m_ph = nph;
  endtask

  function automatic logic [1:0] exp_a();
    return (m_ph == P_GA) ? GREEN : (m_ph == P_YA) ? YELLOW : RED;
  endfunction

  function automatic logic [1:0] exp_b();
    return (m_ph == P_GB) ? GREEN : (m_ph == P_YB) ? YELLOW : RED;
  endfunction

  // Drive one cycle of inputs, advance one edge, settle away from the edge.
  task automatic tick(input bit r, input bit a, input bit b, input bit p);
    reset = r; req_a = a; req_b = b; ped_req = p;
    @(posedge clk);
    model_update(r, a, b, p);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    total++; if (phase !== 3'(P_CLEAR)) $display("FAIL reset_phase got=%0d want=%0d", phase, P_CLEAR); else passed++;
    total++; if (sig_a !== RED || sig_b !== RED) $display("FAIL reset_heads got=%0d/%0d want=0/0", sig_a, sig_b); else passed++;
    total++; if (walk !== 1'b0) $display("FAIL reset_walk got=%0b want=0", walk); else passed++;
  endtask

  task automatic test_rest_saturation();
    int greens = 0;
    tick(0, 0, 0, 0);
    total++; if (sig_a !== GREEN) $display("FAIL rest_enter_ga got=%0d want=%0d", sig_a, GREEN); else passed++;
    // 256 further edges: a wrapping counter would read 0 here
    for (int i = 0; i < 256; i++) begin
      tick(0, 0, 0, 0);
      if (sig_a === GREEN && sig_b === RED) greens++;
    end
    total++; if (greens !== 256) $display("FAIL rest_hold got=%0d want=256", greens); else passed++;
    tick(0, 0, 1, 0);
    total++; if (sig_a !== YELLOW) $display("FAIL rest_saturated got=%0d want=%0d", sig_a, YELLOW); else passed++;
  endtask

  task automatic test_gap_out();
    int greens = 1;
    tick(0, 0, 1, 0);
    total++; if (sig_a !== YELLOW) $display("FAIL gap_yellow2 got=%0d want=%0d", sig_a, YELLOW); else passed++;
    tick(0, 0, 1, 0);
    total++; if (phase !== 3'(P_CLEAR) || sig_a !== RED || sig_b !== RED) $display("FAIL gap_clear got=%0d want=%0d", phase, P_CLEAR); else passed++;
    tick(0, 0, 1, 0);
    total++; if (sig_b !== GREEN) $display("FAIL gap_enter_gb got=%0d want=%0d", sig_b, GREEN); else passed++;
    tick(0, 0, 1, 0);
    if (sig_b === GREEN) greens++;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      if (sig_b !== GREEN) break;
      greens++;
    end
    total++; if (greens !== MIN_GREEN) $display("FAIL gap_b_green_len got=%0d want=%0d", greens, MIN_GREEN); else passed++;
    tick(0, 0, 0, 0);
    total++; if (sig_b !== YELLOW) $display("FAIL gap_b_yellow2 got=%0d want=%0d", sig_b, YELLOW); else passed++;
    tick(0, 0, 0, 0);
    total++; if (phase !== 3'(P_CLEAR)) $display("FAIL gap_b_clear got=%0d want=%0d", phase, P_CLEAR); else passed++;
    tick(0, 0, 0, 0);
    total++; if (sig_a !== GREEN) $display("FAIL gap_back_to_a got=%0d want=%0d", sig_a, GREEN); else passed++;
  endtask

  task automatic test_max_out();
    int greens = 1;
    int holds = 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 1, 0);
      if (sig_a !== GREEN) break;
      greens++;
    end
    total++; if (greens !== MAX_GREEN) $display("FAIL max_a_green_len got=%0d want=%0d", greens, MAX_GREEN); else passed++;
    for (int i = 0; i < 20 && sig_b !== GREEN; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 1, 0);
      if (sig_b === GREEN) holds++;
    end
    total++; if (holds !== 30) $display("FAIL max_b_hold got=%0d want=30", holds); else passed++;
    for (int i = 0; i < 20 && sig_a !== GREEN; i++) tick(0, 0, 0, 0);
    total++; if (sig_a !== GREEN) $display("FAIL max_return_a got=%0d want=%0d", sig_a, GREEN); else passed++;
  endtask

  task automatic test_ped();
    int walks = 0;
    bit heads_ok = 1;
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    total++; if (sig_a !== GREEN) $display("FAIL ped_latch_edge got=%0d want=%0d", sig_a, GREEN); else passed++;
    tick(0, 0, 0, 0);
    total++; if (sig_a !== YELLOW) $display("FAIL ped_yellow got=%0d want=%0d", sig_a, YELLOW); else passed++;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      if (walk !== 1'b1) break;
      walks++;
      if (sig_a !== RED || sig_b !== RED) heads_ok = 0;
    end
    total++; if (walks !== PED_T) $display("FAIL ped_walk_len got=%0d want=%0d", walks, PED_T); else passed++;
    total++; if (heads_ok !== 1'b1) $display("FAIL ped_heads_red got=%0b want=1", heads_ok); else passed++;
    total++; if (phase !== 3'(P_CLEAR)) $display("FAIL ped_clear got=%0d want=%0d", phase, P_CLEAR); else passed++;
    tick(0, 0, 0, 0);
    total++; if (sig_a !== GREEN) $display("FAIL ped_back_to_a got=%0d want=%0d", sig_a, GREEN); else passed++;
  endtask

  task automatic test_ped_with_b();
    bit extra_walk = 0;
    tick(0, 0, 1, 1);
    for (int i = 0; i < 30 && walk !== 1'b1; i++) tick(0, 0, 1, 0);
    total++; if (walk !== 1'b1) $display("FAIL pedb_walk_first got=%0b want=1", walk); else passed++;
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    total++; if (phase !== 3'(P_CLEAR)) $display("FAIL pedb_clear got=%0d want=%0d", phase, P_CLEAR); else passed++;
    tick(0, 0, 1, 0);
    total++; if (sig_b !== GREEN || walk !== 1'b0) $display("FAIL pedb_then_gb got=%0d/%0b want=%0d/0", sig_b, walk, GREEN); else passed++;
    for (int i = 0; i < 15; i++) begin
      tick(0, 0, 0, 0);
      if (walk === 1'b1) extra_walk = 1;
    end
    total++; if (extra_walk !== 1'b0) $display("FAIL pedb_no_second_walk got=%0b want=0", extra_walk); else passed++;
  endtask

  task automatic test_reset_mid_phase();
    for (int i = 0; i < 30 && sig_b !== GREEN; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 30 && sig_b !== YELLOW; i++) tick(0, 0, 0, 0);
    total++; if (sig_b !== YELLOW) $display("FAIL rmid_reach_yb got=%0d want=%0d", sig_b, YELLOW); else passed++;
    tick(1, 0, 0, 1);
    total++; if (sig_a !== RED || sig_b !== RED || walk !== 1'b0) $display("FAIL rmid_abort got=%0d/%0d/%0b want=0/0/0", sig_a, sig_b, walk); else passed++;
    // both approaches demanding: restored last-served=B must favour A
    tick(0, 1, 1, 0);
    total++; if (sig_a !== GREEN || walk !== 1'b0) $display("FAIL rmid_resume_a got=%0d/%0b want=%0d/0", sig_a, walk, GREEN); else passed++;
  endtask

  task automatic test_random();
    int prev_ph;
    bit r, a, b, p;
    for (int i = 0; i < 2000; i++) begin
      prev_ph = m_ph;
      r = ($urandom_range(0, 299) == 0);
      a = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 19) == 0);
      tick(r, a, b, p);
      total++; if (sig_a !== exp_a()) $display("FAIL rand_sig_a cyc=%0d got=%0d want=%0d", i, sig_a, exp_a()); else passed++;
      total++; if (sig_b !== exp_b()) $display("FAIL rand_sig_b cyc=%0d got=%0d want=%0d", i, sig_b, exp_b()); else passed++;
      total++; if (walk !== (m_ph == P_WALK)) $display("FAIL rand_walk cyc=%0d got=%0b want=%0b", i, walk, m_ph == P_WALK); else passed++;
      total++; if (phase !== 3'(m_ph)) $display("FAIL rand_phase cyc=%0d got=%0d want=%0d", i, phase, m_ph); else passed++;
      total++; if (sig_a !== RED && sig_b !== RED) $display("FAIL rand_both_go cyc=%0d got=%0d/%0d want=one RED", i, sig_a, sig_b); else passed++;
      total++; if (walk === 1'b1 && (sig_a !== RED || sig_b !== RED)) $display("FAIL rand_walk_red cyc=%0d got=%0d/%0d want=0/0", i, sig_a, sig_b); else passed++;
      if (!r && (prev_ph == P_GA || prev_ph == P_GB)) begin
        total++;
        if (phase !== 3'(prev_ph) && phase !== 3'(prev_ph + 1))
          $display("FAIL rand_green_seq cyc=%0d got=%0d want=%0d or %0d", i, phase, prev_ph, prev_ph + 1);
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; ped_req = 1'b0;
    test_reset();
    test_rest_saturation();
    test_gap_out();
    test_max_out();
    test_ped();
    test_ped_with_b();
    test_reset_mid_phase();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
